// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO; the frame format is fixed at elaboration.
// txd is registered and idles high. Reset asserts asynchronously and is released to the FSM synchronously.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int GAP_CYCLES  = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, empty, push, pop;
  logic [1:0]           rst_sync_q;
  logic                 hold;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 txd_q, txd_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tick, launch, gap_end;
  logic [DATA_BITS-1:0] head;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = in_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign in_ready   = !full;
  assign fifo_count = count_q;
  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE);
  assign tick       = (timer_q == LAST_TICK);
  assign hold       = rst_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = tick ? '0 : timer_q + TW'(1);
    idx_d   = idx_q;
    gap_d   = gap_q;
    txd_d   = txd_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    launch  = 1'b0;
    gap_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        txd_d   = 1'b1;
        launch  = !empty && !hold;
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        idx_d   = '0;
        txd_d   = shreg_q[0];
      end
      S_DATA: if (tick) begin
        if (idx_q == LAST_DATA) begin
          idx_d = '0;
          if (PARITY != 0) begin
            state_d = S_PAR;
            txd_d   = par_q;
          end else begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end
        end else begin
          idx_d   = idx_q + IW'(1);
          shreg_d = shreg_q >> 1;
          txd_d   = shreg_q[1];
        end
      end
      S_PAR: if (tick) begin
        state_d = S_STOP;
        idx_d   = '0;
        txd_d   = 1'b1;
      end
      S_STOP: if (tick) begin
        if (idx_q == LAST_STOP) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            gap_end = 1'b1;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_GAP: begin
        timer_d = '0;
        if (gap_q == LAST_GAP) gap_end = 1'b1;
        else                   gap_d = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // End of frame chains straight into the next start bit when a word is waiting.
    if (gap_end) begin
      if (!empty) launch = 1'b1;
      else        state_d = S_IDLE;
    end
    if (launch) begin
      pop     = 1'b1;
      shreg_d = head;
      par_d   = (^head) ^ (PARITY == 1);
      txd_d   = 1'b0;
      timer_d = '0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      txd_q   <= 1'b1;
    end else if (hold) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five differently configured instances share one clock and reset.
// Accepted words go onto a scoreboard queue and are matched against frames decoded from txd.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid_a [5];
  logic [8:0] in_data_a  [5];
  logic       in_ready_w [5];
  logic       txd_w      [5];
  logic       busy_w     [5];
  logic [2:0] cnt_w      [5];
  int         errs   = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 8N2 with 8-cycle gap, u4: 7N1
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data_a[0][7:0]), .in_valid(in_valid_a[0]), .in_ready(in_ready_w[0]),
    .txd(txd_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data_a[1][7:0]), .in_valid(in_valid_a[1]), .in_ready(in_ready_w[1]),
    .txd(txd_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data_a[2][7:0]), .in_valid(in_valid_a[2]), .in_ready(in_ready_w[2]),
    .txd(txd_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .GAP_CYCLES(8), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data_a[3][7:0]), .in_valid(in_valid_a[3]), .in_ready(in_ready_w[3]),
    .txd(txd_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data_a[4][6:0]), .in_valid(in_valid_a[4]), .in_ready(in_ready_w[4]),
    .txd(txd_w[4]), .busy(busy_w[4]), .fifo_count(cnt_w[4]));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called just after a negedge; holds valid through the next posedge and returns at the following negedge.
  task automatic offer(input int i, input logic [8:0] d, output bit acc);
    in_valid_a[i] = 1'b1;
    in_data_a[i]  = d;
    acc = in_ready_w[i];
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_fall(input int i, output int waited, output int tf);
    logic prev, cur;
    prev   = txd_w[i];
    waited = -1;
    tf     = -1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      cur = txd_w[i];
      if (prev && !cur) begin
        waited = n;
        tf     = cyc;
        return;
      end
      prev = cur;
    end
    check("start_timeout", 1, 0);
  endtask

  task automatic rx_frame(input int i, input int nbits, input int npar, input int nstop,
                          output logic [63:0] v, output int waited, output int tf, output int bcyc);
    int n;
    n    = (1 + nbits + npar + nstop) * 4;
    v    = '0;
    bcyc = 0;
    wait_fall(i, waited, tf);
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      v[c] = txd_w[i];
      if (busy_w[i]) bcyc++;
    end
  endtask

  function automatic logic [8:0] decode(input logic [63:0] v, input int nbits);
    logic [8:0] d;
    d = '0;
    for (int j = 0; j < nbits; j++) d[j] = v[(1 + j) * 4 + 2];
    return d;
  endfunction

  task automatic sb_check(input string tag, input logic [8:0] got);
    if (exp_q.size() == 0) check({tag, "_sb_underflow"}, 1, 0);
    else                   check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    logic [63:0] v1, v2, expv;
    logic [9:0]  fb;
    logic [5:0]  accv;
    int          w1, w2, t1, t2, b1, b2;
    bit          acc;
    logic [2:0]  cnt6;
    logic        rdy6;

    for (int i = 0; i < 5; i++) begin
      in_valid_a[i] = 1'b0;
      in_data_a[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_state", {txd_w[0], busy_w[0], cnt_w[0], in_ready_w[0]}, {1'b1, 1'b0, 3'd0, 1'b1});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 frame of 0x54, cycle-exact waveform
    offer(0, 9'h54, acc);
    in_valid_a[0] = 1'b0;
    check("t1_acc", acc, 1);
    check("t1_txd_after_push", {txd_w[0], cnt_w[0]}, {1'b1, 3'd1});
    rx_frame(0, 8, 0, 1, v1, w1, t1, b1);
    check("t1_latency", w1, 1);
    fb   = {1'b1, 8'h54, 1'b0};
    expv = '0;
    for (int c = 0; c < 40; c++) expv[c] = fb[c / 4];
    check("t1_wave", v1, expv);
    check("t1_busy_cycles", b1, 40);
    @(negedge clk);
    check("t1_idle_after", {busy_w[0], txd_w[0]}, 2'b01);
    sb_check("t1_data", decode(v1, 8));

    // even and odd parity of 0x07
    offer(1, 9'h07, acc);
    in_valid_a[1] = 1'b0;
    rx_frame(1, 8, 1, 1, v1, w1, t1, b1);
    check("t2_even_parity", v1[38], 1);
    check("t2_even_stop", v1[42], 1);
    check("t2_even_len", b1, 44);
    @(negedge clk);
    check("t2_even_idle", busy_w[1], 0);
    sb_check("t2_even_data", decode(v1, 8));
    offer(2, 9'h07, acc);
    in_valid_a[2] = 1'b0;
    rx_frame(2, 8, 1, 1, v1, w1, t1, b1);
    check("t2_odd_parity", v1[38], 0);
    check("t2_odd_len", b1, 44);
    sb_check("t2_odd_data", decode(v1, 8));
    repeat (2) @(negedge clk);

    // FIFO fill: six offers from idle, five accepted
    accv = '0;
    cnt6 = '0;
    rdy6 = 1'b1;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          if (k == 6) begin
            cnt6 = cnt_w[0];
            rdy6 = in_ready_w[0];
          end
          offer(0, 9'(k), acc);
          accv[k-1] = acc;
        end
        in_valid_a[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rx_frame(0, 8, 0, 1, v1, w1, t1, b1);
          sb_check("t3_data", decode(v1, 8));
        end
      end
    join
    check("t3_accept_mask", accv, 6'b011111);
    check("t3_full_state", {rdy6, cnt6}, {1'b0, 3'd4});
    check("t3_sb_drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("t3_idle", {busy_w[0], cnt_w[0]}, 4'b0000);

    // 8N2 + 8-cycle gap: start edges 52 cycles apart
    fork
      begin
        offer(3, 9'h3C, acc);
        offer(3, 9'hC3, acc);
        in_valid_a[3] = 1'b0;
      end
      begin
        rx_frame(3, 8, 0, 2, v1, w1, t1, b1);
        rx_frame(3, 8, 0, 2, v2, w2, t2, b2);
      end
    join
    check("t4_spacing", t2 - t1, 52);
    check("t4_stops", {v1[38], v1[42], v2[38], v2[42]}, 4'b1111);
    sb_check("t4_data0", decode(v1, 8));
    sb_check("t4_data1", decode(v2, 8));
    repeat (16) @(negedge clk);

    // reset during data bit 3 aborts the frame asynchronously
    fork
      begin
        offer(0, 9'h00, acc);
        offer(0, 9'h11, acc);
        offer(0, 9'h22, acc);
        in_valid_a[0] = 1'b0;
      end
      begin
        wait_fall(0, w1, t1);
        repeat (17) @(negedge clk);
      end
    join
    check("t5_before_reset", {txd_w[0], busy_w[0], cnt_w[0]}, {1'b0, 1'b1, 3'd2});
    #1 rst = 1'b1;
    #1 check("t5_async_reset", {txd_w[0], busy_w[0], cnt_w[0], in_ready_w[0]}, {1'b1, 1'b0, 3'd0, 1'b1});
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_quiet_after", {txd_w[0], busy_w[0]}, 2'b10);
    fork
      begin
        offer(0, 9'hA5, acc);
        in_valid_a[0] = 1'b0;
      end
      rx_frame(0, 8, 0, 1, v1, w1, t1, b1);
    join
    check("t5_stop", v1[38], 1);
    sb_check("t5_data", decode(v1, 8));
    check("t5_sb_drained", exp_q.size(), 0);

    // 7-bit data, no parity: 9-bit frame
    offer(4, 9'h7F, acc);
    in_valid_a[4] = 1'b0;
    rx_frame(4, 7, 0, 1, v1, w1, t1, b1);
    check("t6_start_stop", {v1[2], v1[34]}, 2'b01);
    check("t6_len", b1, 36);
    @(negedge clk);
    check("t6_idle", {busy_w[4], txd_w[4]}, 2'b01);
    sb_check("t6_data", decode(v1, 7));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
